// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with double-buffered value
// loading, leading-zero blanking and selectable output polarity.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1,
  parameter int LZ_BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic INVERT = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic                    tick;
  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   an_raw;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              seg_raw;

  assign tick       = (cnt == CNT_LAST);
  assign frame_tick = tick && (idx == IDX_LAST);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  // lz[i]: every nibble and dp from position i up to the top digit is zero
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (act_val[4*NUM_DIGITS-1 -: 4] == 4'h0) && !act_dp[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (act_val[4*i +: 4] == 4'h0) && !act_dp[i];
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = act_val[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = (LZ_BLANK != 0) && (i > 0) && lz[i];
        an_raw[i] = 1'b1;
      end
    end
    seg_raw = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= '0;
      pend_val       <= '0;
      pend_dp        <= '0;
      act_val        <= '0;
      act_dp         <= '0;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
      seg            <= {7{INVERT}};
      dp             <= INVERT;
      an             <= {NUM_DIGITS{INVERT}};
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      frame_done <= frame_tick;

      // Swap only at a frame edge so a frame never mixes old and new digits
      if (frame_tick && update_pending) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_val       <= value_in;
        pend_dp        <= dp_in;
        update_pending <= 1'b1;
      end else if (frame_tick) begin
        update_pending <= 1'b0;
      end

      seg <= seg_raw ^ {7{INVERT}};
      dp  <= cur_dp ^ INVERT;
      an  <= an_raw ^ {NUM_DIGITS{INVERT}};
    end
  end

endmodule
